encode_arbiter: RTL
===================

ENCODE_ARBITER -- requirements
Module: encode_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles WAIT may last before abort (>=8).
REQ-003 SHALL have input clk, 1 bit, the clock; all flops on posedge.
REQ-004 SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have input req_valid, NUM_CH bits, per-channel frame request.
REQ-006 SHALL have input req_data, NUM_CH*128 bits, channel i message in bits [128*i+127:128*i].
REQ-007 SHALL have output req_ready, NUM_CH bits, per-channel accept.
REQ-008 SHALL have output rsp_valid, NUM_CH bits, one-hot one-cycle codeword-ready pulse.
REQ-009 SHALL have output rsp_data, 256 bits, shared codeword bus, valid when any rsp_valid bit is high.
REQ-010 SHALL have output enc_data_in, 128 bits, message to the encoder.
REQ-011 SHALL have output enc_valid_i, 1 bit, encoder start strobe.
REQ-012 SHALL have input enc_ready_o, 1 bit, encoder idle indication.
REQ-013 SHALL have input enc_data_out, 256 bits, encoder codeword.
REQ-014 SHALL have input enc_valid_o, 1 bit, encoder codeword strobe.
REQ-015 SHALL have output grant_id, 3 bits, index of the channel currently owning the encoder.
REQ-016 SHALL have output busy, 1 bit, high in every state except IDLE.
REQ-017 SHALL have output timeout_err, 1 bit, one-cycle abort pulse.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 SHALL, in IDLE with enc_ready_o=1 and any req_valid set, select channel g round-robin: first set bit searching upward from last_grant+1, wrapping modulo NUM_CH.
REQ-020 SHALL drive req_ready combinationally as onehot(g) only in IDLE with enc_ready_o=1 and a set req_valid; all zeros otherwise.
REQ-021 SHALL, on the accept cycle, register req_data slice g into a 128-bit hold register, set grant_id=g and last_grant=g, and go to ISSUE.
REQ-022 SHALL, in ISSUE, drive enc_valid_i=1 for exactly one cycle with enc_data_in=hold register, then go to WAIT.
REQ-023 SHALL hold enc_data_in stable at the hold register at all times after accept; enc_valid_i=0 outside ISSUE.
REQ-024 SHALL, in WAIT, count cycles from 0; on enc_valid_o=1, capture enc_data_out into rsp_data and go to RESP.
REQ-025 SHALL, in RESP, assert rsp_valid[grant_id]=1 for one cycle, then return to IDLE; the next grant is evaluated no earlier than the cycle after RESP.
REQ-026 SHALL, if the WAIT count reaches TIMEOUT-1 with no enc_valid_o, pulse timeout_err for one cycle, assert no rsp_valid, and return to IDLE.
REQ-027 SHALL ignore enc_valid_o outside WAIT, including a late codeword after a timeout.
REQ-028 SHALL stay in IDLE with req_ready=0 while enc_ready_o=0, regardless of req_valid.
REQ-029 SHALL hold rsp_data stable from capture until the next capture.
REQ-030 SHALL give end-to-end latency, accept to rsp_valid, of encoder latency + 3 cycles (ISSUE, capture, RESP).

Reset
REQ-031 SHALL, on rst_n=0 at any time, asynchronously force state=IDLE, last_grant=NUM_CH-1, grant_id=0, the hold register, enc_data_in and rsp_data to 0, and enc_valid_i, rsp_valid, timeout_err and busy to 0; req_ready follows REQ-020 from IDLE.
REQ-032 SHALL, after a reset mid-transaction, discard the frame in flight with no rsp_valid and no timeout_err.

Verification
REQ-033 SHALL cover: only ch2 valid with data 0x...0001, encoder latency 4 -> req_ready=0b0100, one enc_valid_i cycle with that data, rsp_valid=0b0100 seven cycles after accept, busy high throughout.
REQ-034 SHALL cover: ch0..ch3 all held valid for 4 frames -> grants in order 0,1,2,3; then only ch1 and ch3 valid -> grants 1,3,1.
REQ-035 SHALL cover: enc_valid_o never asserted, TIMEOUT=64 -> timeout_err pulse 64 cycles into WAIT, no rsp_valid, FSM in IDLE.
REQ-036 SHALL cover: enc_ready_o held 0 for 10 cycles with req_valid=0b0001 -> req_ready stays 0; grant occurs in the first cycle enc_ready_o=1.
REQ-037 SHALL cover: rst_n pulsed low during WAIT -> all outputs reset immediately; the late enc_valid_o is ignored; the next request is served normally starting from ch0 priority.
REQ-038 SHALL cover: stray enc_valid_o in IDLE with data 0xFFFF... -> rsp_valid stays 0 and rsp_data is unchanged.

Source files
------------

// File: rtl/encode_arbiter.sv
// Round-robin arbiter sharing one 128->256 bit encoder among NUM_CH requesters.
// One frame in flight at a time: accept, issue, wait for the codeword (or time out), respond.
module encode_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*128-1:0]   req_data,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH-1:0]       rsp_valid,
  output logic [255:0]            rsp_data,
  output logic [127:0]            enc_data_in,
  output logic                    enc_valid_i,
  input  logic                    enc_ready_o,
  input  logic [255:0]            enc_data_out,
  input  logic                    enc_valid_o,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  logic [2:0]          r_lastGrant;
  logic [2:0]          r_grantId;
  logic [127:0]        r_holdData;
  logic [255:0]        r_rspData;
  logic [NUM_CH-1:0]   r_rspValid;
  logic                r_encValid;
  logic                r_busy;
  logic                r_timeoutErr;
  logic [CW-1:0]       r_waitCnt;

  logic                w_found;
  logic                w_accept;
  logic [2:0]          w_grant;
  logic [3:0]          w_cand;
  logic [7:0]          w_reqPad;
  logic [127:0]        w_chData [8];

  assign w_reqPad = 8'(req_valid);

  // Channels are padded out to 8 so a 3-bit grant index always selects a legal entry.
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      assign w_chData[i] = req_data[i*128 +: 128];
    end else begin : g_off
      assign w_chData[i] = '0;
    end
  end

  // Search upward from the previous owner, wrapping at NUM_CH; first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = 4'(r_lastGrant) + 4'(k);
      if (w_cand >= 4'(NUM_CH)) begin
        w_cand = w_cand - 4'(NUM_CH);
      end
      if (!w_found && w_reqPad[w_cand[2:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[2:0];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && enc_ready_o && w_found;
  assign req_ready = w_accept ? (NUM_CH'(1) << w_grant) : '0;

  // A codeword arriving outside WAIT is never looked at, so late or stray strobes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lastGrant  <= 3'(NUM_CH - 1);
      r_grantId    <= '0;
      r_holdData   <= '0;
      r_rspData    <= '0;
      r_rspValid   <= '0;
      r_encValid   <= 1'b0;
      r_busy       <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_waitCnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rspValid   <= '0;
          r_timeoutErr <= 1'b0;
          if (w_accept) begin
            r_holdData  <= w_chData[w_grant];
            r_grantId   <= w_grant;
            r_lastGrant <= w_grant;
            r_encValid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_encValid <= 1'b0;
          r_waitCnt  <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (enc_valid_o) begin
            r_rspData  <= enc_data_out;
            r_rspValid <= NUM_CH'(1) << r_grantId;
            r_state    <= RESP;
          end else if (r_waitCnt == CW'(TIMEOUT - 1)) begin
            r_timeoutErr <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        RESP: begin
          r_rspValid <= '0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign enc_data_in = r_holdData;
  assign enc_valid_i = r_encValid;
  assign grant_id    = r_grantId;
  assign busy        = r_busy;
  assign timeout_err = r_timeoutErr;

endmodule
